// File: rtl/system_run_ctrl_if.sv
// rtl/system_run_ctrl_if.sv - request/status bundle between run controller and its master
//
// Purpose: groups the run-control requests, per-hart strobes and the controller's
//          status outputs into one bundle.
// Signals:
//   run_req, step_req, halt_req, sw_rst_req   master -> ctrl  one-cycle request pulses
//   hart_mask                                 master -> ctrl  participating harts
//   hart_retire, hart_halt                    harts  -> ctrl  retire strobe / halt level
//   hart_nrst, hart_en                        ctrl   -> harts per-hart reset / execute enable
//   state, cycle_cnt, instret_cnt, wdt_err    ctrl   -> master status
// Modports: master (request side), slave (controller side).

interface system_run_ctrl_if #(
    parameter int NUM_HARTS = 1,
    parameter int CNT_W     = 32
) ();
    logic                 run_req;
    logic                 step_req;
    logic                 halt_req;
    logic                 sw_rst_req;
    logic [NUM_HARTS-1:0] hart_mask;
    logic [NUM_HARTS-1:0] hart_retire;
    logic [NUM_HARTS-1:0] hart_halt;
    logic [NUM_HARTS-1:0] hart_nrst;
    logic [NUM_HARTS-1:0] hart_en;
    logic [1:0]           state;
    logic [CNT_W-1:0]     cycle_cnt;
    logic [CNT_W-1:0]     instret_cnt;
    logic                 wdt_err;

    modport master (
        output run_req, step_req, halt_req, sw_rst_req, hart_mask, hart_retire, hart_halt,
        input  hart_nrst, hart_en, state, cycle_cnt, instret_cnt, wdt_err
    );

    modport slave (
        input  run_req, step_req, halt_req, sw_rst_req, hart_mask, hart_retire, hart_halt,
        output hart_nrst, hart_en, state, cycle_cnt, instret_cnt, wdt_err
    );
endinterface

// File: rtl/system_run_ctrl.sv
// rtl/system_run_ctrl.sv - multi-hart run controller: reset sequencing, run/step gating, counters
//
// Purpose: holds all harts in reset for RST_HOLD_CYCLES after power-up or a software
//          reset, then gates the datapath harts through IDLE / RUN / STEP and keeps
//          cycle and retired-instruction counters.
// Ports:
//   clk    system clock, rising edge
//   nrst   asynchronous active-low reset
//   bus    system_run_ctrl_if.slave (requests, hart strobes, hart_nrst/hart_en, status)
// Optional feature: define SYSTEM_WDT_EN to build the no-retire watchdog; without it
//          wdt_err is tied low and WDT_CYCLES is unused.

module system_run_ctrl #(
    parameter int NUM_HARTS       = 1,
    parameter int RST_HOLD_CYCLES = 4,
    parameter int CNT_W           = 32,
    parameter int WDT_CYCLES      = 1024
) (
    input  logic              clk,
    input  logic              nrst,
    system_run_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_RESET = 2'b00;
    localparam logic [1:0] ST_IDLE  = 2'b01;
    localparam logic [1:0] ST_RUN   = 2'b10;
    localparam logic [1:0] ST_STEP  = 2'b11;

    // Hold counter only needs to reach RST_HOLD_CYCLES-1.
    localparam int HOLD_W = (RST_HOLD_CYCLES < 2) ? 1 : $clog2(RST_HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    logic [1:0]           state_q,   state_d;
    logic [HOLD_W-1:0]    hold_q,    hold_d;
    logic [NUM_HARTS-1:0] mask_q,    mask_d;
    logic [NUM_HARTS-1:0] done_q,    done_d;
    logic [CNT_W-1:0]     cycle_q,   cycle_d;
    logic [CNT_W-1:0]     instret_q, instret_d;

    logic [NUM_HARTS-1:0] hart_en;
    logic [NUM_HARTS-1:0] counted;
    logic [NUM_HARTS-1:0] done_set;
    logic [CNT_W-1:0]     retire_num;
    logic                 active;
    logic                 accept;
    logic                 wdt_timeout;

    // Enables depend only on registered state, so a request sampled at one edge
    // shows up on hart_en in the following cycle.
    always_comb begin
        hart_en = '0;
        case (state_q)
            ST_RUN:  hart_en = mask_q;
            ST_STEP: hart_en = mask_q & ~done_q;
            default: hart_en = '0;
        endcase
    end

    assign active  = (state_q == ST_RUN) || (state_q == ST_STEP);
    // A retire strobe from a stalled hart is neither counted nor marks it done.
    assign counted = bus.hart_retire & hart_en;

    always_comb begin
        retire_num = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            retire_num = retire_num + CNT_W'(counted[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        mask_d    = mask_q;
        done_d    = done_q;
        accept    = 1'b0;
        done_set  = done_q | counted | (bus.hart_halt & mask_q);
        cycle_d   = cycle_q + CNT_W'(active);
        instret_d = instret_q + retire_num;

        case (state_q)
            ST_RESET: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_IDLE: begin
                // halt_req outranks run/step; an empty mask makes the request a no-op.
                if (!bus.halt_req && (|bus.hart_mask) && (bus.run_req || bus.step_req)) begin
                    state_d = bus.run_req ? ST_RUN : ST_STEP;
                    mask_d  = bus.hart_mask;
                    done_d  = '0;
                    accept  = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.halt_req || ((bus.hart_halt & mask_q) == mask_q) || wdt_timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                done_d = done_set;
                if (bus.halt_req || ((done_set & mask_q) == mask_q) || wdt_timeout) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Software reset overrides everything and restarts the hold sequence.
        if (bus.sw_rst_req) begin
            state_d   = ST_RESET;
            hold_d    = '0;
            mask_d    = '0;
            done_d    = '0;
            cycle_d   = '0;
            instret_d = '0;
            accept    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_RESET;
            hold_q    <= '0;
            mask_q    <= '0;
            done_q    <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            mask_q    <= mask_d;
            done_q    <= done_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

`ifdef SYSTEM_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             wdt_err_q;

    // Counts consecutive RUN/STEP cycles without a counted retire.
    always_comb begin
        wdt_timeout = 1'b0;
        wdt_d       = wdt_q;
        if (!active || (|counted)) begin
            wdt_d = '0;
        end else if ((wdt_q + 1'b1) == WDT_W'(WDT_CYCLES)) begin
            wdt_timeout = 1'b1;
            wdt_d       = '0;
        end else begin
            wdt_d = wdt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wdt_q     <= '0;
            wdt_err_q <= 1'b0;
        end else begin
            wdt_q <= bus.sw_rst_req ? '0 : wdt_d;
            if (bus.sw_rst_req || accept) begin
                wdt_err_q <= 1'b0;
            end else if (wdt_timeout) begin
                wdt_err_q <= 1'b1;
            end
        end
    end

    assign bus.wdt_err = wdt_err_q;
`else
    logic unused_ok;
    assign wdt_timeout = 1'b0;
    assign bus.wdt_err = 1'b0;
    assign unused_ok   = accept ^ (WDT_CYCLES != 0);
`endif

    assign bus.state       = state_q;
    assign bus.hart_en     = hart_en;
    assign bus.hart_nrst   = (state_q == ST_RESET) ? '0 : '1;
    assign bus.cycle_cnt   = cycle_q;
    assign bus.instret_cnt = instret_q;

endmodule

// File: tb/tb_system_run_ctrl.sv
// tb/tb_system_run_ctrl.sv - randomized self-checking bench for system_run_ctrl

module tb_system_run_ctrl;
    localparam int NH   = 2;
    localparam int HOLD = 4;
    localparam int CW   = 8;
    localparam int WDT  = 8;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    system_run_ctrl_if #(.NUM_HARTS(NH), .CNT_W(CW)) bus ();

    system_run_ctrl #(
        .NUM_HARTS(NH), .RST_HOLD_CYCLES(HOLD), .CNT_W(CW), .WDT_CYCLES(WDT)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;
    logic [CW-1:0] exp_cyc = '0;
    logic [CW-1:0] exp_inst = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.state, bus.hart_nrst, bus.hart_en, bus.cycle_cnt, bus.instret_cnt, bus.wdt_err} !== '0)
            $display("FAIL reset_state: got %h expected 0",
                     {bus.state, bus.hart_nrst, bus.hart_en, bus.cycle_cnt, bus.instret_cnt, bus.wdt_err});
        else passes++;
        nrst = 1'b1;
        exp_cyc = '0;
        exp_inst = '0;
        for (int i = 0; i < HOLD; i++) begin
            checks++;
            if ({bus.state, bus.hart_nrst, bus.hart_en} !== 6'b00_00_00)
                $display("FAIL reset_hold%0d: got %h expected 00", i, {bus.state, bus.hart_nrst, bus.hart_en});
            else passes++;
            tick();
        end
        checks++;
        if ({bus.state, bus.hart_nrst, bus.hart_en} !== 6'b01_11_00)
            $display("FAIL reset_release: got %h expected %h", {bus.state, bus.hart_nrst, bus.hart_en}, 6'b01_11_00);
        else passes++;
    endtask

    task automatic test_run_directed();
        bus.hart_mask = 2'b11;
        bus.run_req = 1'b1;
        tick();
        bus.run_req = 1'b0;
        bus.hart_mask = 2'b00;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({bus.state, bus.hart_en} !== 4'b10_11)
                $display("FAIL run_dir_en%0d: got %h expected %h", c, {bus.state, bus.hart_en}, 4'b10_11);
            else passes++;
            bus.hart_retire = 2'b11;
            tick();
            exp_inst += CW'(2);
            exp_cyc += 1'b1;
        end
        bus.hart_retire = 2'b00;
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        exp_cyc += 1'b1;
        checks++;
        if ({bus.state, bus.hart_en, bus.cycle_cnt, bus.instret_cnt} !== {2'b01, 2'b00, exp_cyc, exp_inst})
            $display("FAIL run_dir_end: got %h expected %h",
                     {bus.state, bus.hart_en, bus.cycle_cnt, bus.instret_cnt}, {2'b01, 2'b00, exp_cyc, exp_inst});
        else passes++;
    endtask

    task automatic test_run_random();
        logic [NH-1:0] m;
        logic [NH-1:0] r;
        int n;
        for (int it = 0; it < 4; it++) begin
            m = NH'($urandom_range(1, 3));
            n = $urandom_range(3, 12);
            bus.hart_mask = m;
            bus.run_req = 1'b1;
            tick();
            bus.run_req = 1'b0;
            bus.hart_mask = NH'($urandom);
            for (int c = 0; c < n; c++) begin
                checks++;
                if ({bus.state, bus.hart_en} !== {2'b10, m})
                    $display("FAIL run_rand%0d_c%0d: got %h expected %h", it, c, {bus.state, bus.hart_en}, {2'b10, m});
                else passes++;
                r = NH'($urandom);
                if (c % 4 == 0) r = '1;
                bus.hart_retire = r;
                bus.run_req = 1'($urandom_range(0, 1));
                bus.step_req = 1'($urandom_range(0, 1));
                tick();
                exp_inst += CW'($countones(r & m));
                exp_cyc += 1'b1;
            end
            bus.hart_retire = '0;
            bus.run_req = 1'b0;
            bus.step_req = 1'b0;
            bus.halt_req = 1'b1;
            tick();
            bus.halt_req = 1'b0;
            exp_cyc += 1'b1;
            checks++;
            if ({bus.state, bus.hart_en, bus.cycle_cnt, bus.instret_cnt} !== {2'b01, 2'b00, exp_cyc, exp_inst})
                $display("FAIL run_rand%0d_end: got %h expected %h", it,
                         {bus.state, bus.hart_en, bus.cycle_cnt, bus.instret_cnt}, {2'b01, 2'b00, exp_cyc, exp_inst});
            else passes++;
        end
    endtask

    task automatic test_step_directed();
        logic [1:0] en_seq [3] = '{2'b11, 2'b10, 2'b10};
        logic [1:0] ret_seq [3] = '{2'b01, 2'b00, 2'b11};
        bus.hart_mask = 2'b11;
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({bus.state, bus.hart_en} !== {2'b11, en_seq[c]})
                $display("FAIL step_dir_c%0d: got %h expected %h", c, {bus.state, bus.hart_en}, {2'b11, en_seq[c]});
            else passes++;
            bus.hart_retire = ret_seq[c];
            tick();
            exp_cyc += 1'b1;
        end
        bus.hart_retire = 2'b00;
        exp_inst += CW'(2);
        checks++;
        if ({bus.state, bus.hart_en, bus.cycle_cnt, bus.instret_cnt} !== {2'b01, 2'b00, exp_cyc, exp_inst})
            $display("FAIL step_dir_end: got %h expected %h",
                     {bus.state, bus.hart_en, bus.cycle_cnt, bus.instret_cnt}, {2'b01, 2'b00, exp_cyc, exp_inst});
        else passes++;
    endtask

    task automatic test_step_random();
        logic [NH-1:0] m;
        logic [NH-1:0] r;
        logic [NH-1:0] en_exp;
        int d [NH];
        int dmax;
        for (int it = 0; it < 4; it++) begin
            m = NH'($urandom_range(1, 3));
            dmax = 0;
            for (int i = 0; i < NH; i++) begin
                d[i] = $urandom_range(1, 4);
                if (m[i] && d[i] > dmax) dmax = d[i];
            end
            bus.hart_mask = m;
            bus.step_req = 1'b1;
            tick();
            bus.step_req = 1'b0;
            bus.hart_mask = NH'($urandom);
            for (int c = 1; c <= dmax; c++) begin
                for (int i = 0; i < NH; i++) begin
                    en_exp[i] = m[i] && (c <= d[i]);
                    if (m[i] && c == d[i]) r[i] = 1'b1;
                    else if (!m[i] || c > d[i]) r[i] = 1'($urandom_range(0, 1));
                    else r[i] = 1'b0;
                    if (m[i] && c == d[i]) exp_inst += 1'b1;
                end
                checks++;
                if ({bus.state, bus.hart_en} !== {2'b11, en_exp})
                    $display("FAIL step_rand%0d_c%0d: got %h expected %h", it, c, {bus.state, bus.hart_en}, {2'b11, en_exp});
                else passes++;
                bus.hart_retire = r;
                tick();
                exp_cyc += 1'b1;
            end
            bus.hart_retire = '0;
            checks++;
            if ({bus.state, bus.hart_en, bus.cycle_cnt, bus.instret_cnt} !== {2'b01, 2'b00, exp_cyc, exp_inst})
                $display("FAIL step_rand%0d_end: got %h expected %h", it,
                         {bus.state, bus.hart_en, bus.cycle_cnt, bus.instret_cnt}, {2'b01, 2'b00, exp_cyc, exp_inst});
            else passes++;
        end
    endtask

    task automatic test_ignored();
        bus.hart_mask = 2'b11;
        bus.run_req = 1'b1;
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        checks++;
        if ({bus.state, bus.hart_en} !== 4'b01_00)
            $display("FAIL ign_run_halt: got %h expected %h", {bus.state, bus.hart_en}, 4'b01_00);
        else passes++;
        bus.hart_mask = 2'b00;
        tick();
        checks++;
        if ({bus.state, bus.hart_en} !== 4'b01_00)
            $display("FAIL ign_run_mask0: got %h expected %h", {bus.state, bus.hart_en}, 4'b01_00);
        else passes++;
        bus.run_req = 1'b0;
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        checks++;
        if ({bus.state, bus.hart_en, bus.cycle_cnt} !== {2'b01, 2'b00, exp_cyc})
            $display("FAIL ign_step_mask0: got %h expected %h", {bus.state, bus.hart_en, bus.cycle_cnt}, {2'b01, 2'b00, exp_cyc});
        else passes++;
    endtask

    task automatic test_halt_level();
        bus.hart_mask = 2'b11;
        bus.run_req = 1'b1;
        tick();
        bus.run_req = 1'b0;
        bus.hart_halt = 2'b01;
        tick();
        exp_cyc += 1'b1;
        checks++;
        if ({bus.state, bus.hart_en} !== 4'b10_11)
            $display("FAIL halt_partial: got %h expected %h", {bus.state, bus.hart_en}, 4'b10_11);
        else passes++;
        bus.hart_halt = 2'b11;
        tick();
        exp_cyc += 1'b1;
        bus.hart_halt = 2'b00;
        checks++;
        if ({bus.state, bus.hart_en, bus.cycle_cnt} !== {2'b01, 2'b00, exp_cyc})
            $display("FAIL halt_all: got %h expected %h", {bus.state, bus.hart_en, bus.cycle_cnt}, {2'b01, 2'b00, exp_cyc});
        else passes++;
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        bus.hart_retire = 2'b01;
        bus.hart_halt = 2'b10;
        tick();
        bus.hart_retire = 2'b00;
        bus.hart_halt = 2'b00;
        exp_cyc += 1'b1;
        exp_inst += 1'b1;
        checks++;
        if ({bus.state, bus.hart_en, bus.cycle_cnt, bus.instret_cnt} !== {2'b01, 2'b00, exp_cyc, exp_inst})
            $display("FAIL step_halt_done: got %h expected %h",
                     {bus.state, bus.hart_en, bus.cycle_cnt, bus.instret_cnt}, {2'b01, 2'b00, exp_cyc, exp_inst});
        else passes++;
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        exp_cyc += 1'b1;
        checks++;
        if ({bus.state, bus.hart_en, bus.cycle_cnt} !== {2'b01, 2'b00, exp_cyc})
            $display("FAIL step_halt_req: got %h expected %h", {bus.state, bus.hart_en, bus.cycle_cnt}, {2'b01, 2'b00, exp_cyc});
        else passes++;
    endtask

    task automatic test_sw_rst();
        bus.hart_mask = 2'b11;
        bus.run_req = 1'b1;
        tick();
        bus.run_req = 1'b0;
        bus.hart_retire = 2'b11;
        tick();
        tick();
        bus.hart_retire = 2'b00;
        bus.sw_rst_req = 1'b1;
        bus.run_req = 1'b1;
        bus.halt_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        bus.run_req = 1'b0;
        bus.halt_req = 1'b0;
        exp_cyc = '0;
        exp_inst = '0;
        for (int i = 0; i < HOLD; i++) begin
            checks++;
            if ({bus.state, bus.hart_nrst, bus.hart_en, bus.cycle_cnt, bus.instret_cnt} !== '0)
                $display("FAIL swrst_hold%0d: got %h expected 0", i,
                         {bus.state, bus.hart_nrst, bus.hart_en, bus.cycle_cnt, bus.instret_cnt});
            else passes++;
            tick();
        end
        checks++;
        if ({bus.state, bus.hart_nrst} !== 4'b01_11)
            $display("FAIL swrst_release: got %h expected %h", {bus.state, bus.hart_nrst}, 4'b01_11);
        else passes++;
    endtask

    task automatic test_wrap();
        bus.hart_mask = 2'b01;
        bus.run_req = 1'b1;
        tick();
        bus.run_req = 1'b0;
        bus.hart_retire = 2'b01;
        for (int c = 0; c < 256; c++) begin
            tick();
            exp_cyc += 1'b1;
            exp_inst += 1'b1;
        end
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        bus.hart_retire = 2'b00;
        exp_cyc += 1'b1;
        exp_inst += 1'b1;
        checks++;
        if ({bus.state, bus.cycle_cnt, bus.instret_cnt} !== {2'b01, exp_cyc, exp_inst})
            $display("FAIL wrap: got %h expected %h", {bus.state, bus.cycle_cnt, bus.instret_cnt}, {2'b01, exp_cyc, exp_inst});
        else passes++;
    endtask

    task automatic test_wdt();
        bus.hart_mask = 2'b01;
        bus.run_req = 1'b1;
        tick();
        bus.run_req = 1'b0;
`ifdef SYSTEM_WDT_EN
        for (int c = 0; c < WDT; c++) begin
            checks++;
            if ({bus.state, bus.wdt_err} !== 3'b10_0)
                $display("FAIL wdt_run%0d: got %h expected %h", c, {bus.state, bus.wdt_err}, 3'b10_0);
            else passes++;
            tick();
            exp_cyc += 1'b1;
        end
        checks++;
        if ({bus.state, bus.wdt_err, bus.cycle_cnt} !== {2'b01, 1'b1, exp_cyc})
            $display("FAIL wdt_fire: got %h expected %h", {bus.state, bus.wdt_err, bus.cycle_cnt}, {2'b01, 1'b1, exp_cyc});
        else passes++;
        bus.run_req = 1'b1;
        tick();
        bus.run_req = 1'b0;
        checks++;
        if ({bus.state, bus.wdt_err} !== 3'b10_0)
            $display("FAIL wdt_clear: got %h expected %h", {bus.state, bus.wdt_err}, 3'b10_0);
        else passes++;
`else
        for (int c = 0; c < 20; c++) begin
            tick();
            exp_cyc += 1'b1;
        end
        checks++;
        if ({bus.state, bus.wdt_err} !== 3'b10_0)
            $display("FAIL nowdt_run: got %h expected %h", {bus.state, bus.wdt_err}, 3'b10_0);
        else passes++;
`endif
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        exp_cyc += 1'b1;
        checks++;
        if ({bus.state, bus.cycle_cnt} !== {2'b01, exp_cyc})
            $display("FAIL wdt_end: got %h expected %h", {bus.state, bus.cycle_cnt}, {2'b01, exp_cyc});
        else passes++;
    endtask

    task automatic test_async_reset();
        bus.hart_mask = 2'b11;
        bus.run_req = 1'b1;
        tick();
        bus.run_req = 1'b0;
        bus.hart_retire = 2'b10;
        tick();
        tick();
        bus.hart_retire = 2'b00;
        #2;
        nrst = 1'b0;
        #1;
        checks++;
        if ({bus.state, bus.hart_nrst, bus.hart_en, bus.cycle_cnt, bus.instret_cnt, bus.wdt_err} !== '0)
            $display("FAIL async_rst: got %h expected 0",
                     {bus.state, bus.hart_nrst, bus.hart_en, bus.cycle_cnt, bus.instret_cnt, bus.wdt_err});
        else passes++;
        tick();
        nrst = 1'b1;
        for (int i = 0; i < HOLD; i++) tick();
        checks++;
        if ({bus.state, bus.hart_nrst, bus.cycle_cnt} !== {2'b01, 2'b11, {CW{1'b0}}})
            $display("FAIL async_release: got %h expected %h", {bus.state, bus.hart_nrst, bus.cycle_cnt},
                     {2'b01, 2'b11, {CW{1'b0}}});
        else passes++;
    endtask

    initial begin
        nrst = 1'b0;
        bus.run_req = 1'b0;
        bus.step_req = 1'b0;
        bus.halt_req = 1'b0;
        bus.sw_rst_req = 1'b0;
        bus.hart_mask = '0;
        bus.hart_retire = '0;
        bus.hart_halt = '0;
        test_reset();
        test_run_directed();
        test_run_random();
        test_step_directed();
        test_step_random();
        test_ignored();
        test_halt_level();
        test_sw_rst();
        test_wrap();
        test_wdt();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
